// File: rtl/mul_seq.sv
// Sequential RV32M multiplier on the PCPI interface: one carry-save shift-and-add
// step per clock over a 64-bit accumulator, with the carries resolved in a final cycle.
module mul_seq #(
  parameter int CARRY_CHAIN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready
);
  localparam int SEGW = (CARRY_CHAIN == 0) ? 64 : CARRY_CHAIN;
  localparam int NSEG = 64 / SEGW;

  typedef enum logic [1:0] {IDLE, RUN, RESOLVE} state_t;

  state_t      state_reg, state_next;
  logic [63:0] rs1_reg, rs1_next;
  logic [63:0] rs2_reg, rs2_next;
  logic [63:0] rd_reg, rd_next;
  logic [63:0] rdx_reg, rdx_next;
  logic [6:0]  cnt_reg, cnt_next;
  logic        is_mul_reg, is_mul_next;
  logic [31:0] out_reg, out_next;
  logic        ready_reg, ready_next;
  logic        wait_reg, wait_next;

  logic [2:0]  funct3;
  logic        insn_mul;
  logic [63:0] this_rs2;
  logic [63:0] step_rd;
  logic [63:0] step_rdt;
  logic [63:0] sum;
  logic        unused_insn;

  assign funct3      = pcpi_insn[14:12];
  assign insn_mul    = (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000001) && !funct3[2];
  assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  assign this_rs2 = rs1_reg[0] ? rs2_reg : 64'd0;
  assign sum      = rd_reg + rdx_reg;

  generate
    if (CARRY_CHAIN == 0) begin : g_ripple
      assign step_rd  = rd_reg + rdx_reg + this_rs2;
      assign step_rdt = 64'd0;
    end else begin : g_csa
      // rdx carries at most one set bit per segment (its LSB), so a segment sum
      // never needs more than one carry-out bit.
      for (genvar gi = 0; gi < NSEG; gi++) begin : g_seg
        logic [SEGW:0] seg_sum;
        assign seg_sum = {1'b0, rd_reg[gi*SEGW +: SEGW]}
                       + {1'b0, rdx_reg[gi*SEGW +: SEGW]}
                       + {1'b0, this_rs2[gi*SEGW +: SEGW]};
        assign step_rd[gi*SEGW +: SEGW]  = seg_sum[SEGW-1:0];
        assign step_rdt[gi*SEGW +: SEGW] = SEGW'(seg_sum[SEGW]) << (SEGW - 1);
      end
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    rs1_next    = rs1_reg;
    rs2_next    = rs2_reg;
    rd_next     = rd_reg;
    rdx_next    = rdx_reg;
    cnt_next    = cnt_reg;
    is_mul_next = is_mul_reg;
    out_next    = out_reg;
    ready_next  = 1'b0;
    wait_next   = wait_reg;
    case (state_reg)
      IDLE: begin
        wait_next = 1'b0;
        // The ready cycle is spent in IDLE; the still-asserted request must not restart.
        if (pcpi_valid && insn_mul && !ready_reg) begin
          state_next  = RUN;
          wait_next   = 1'b1;
          rs1_next    = {{32{pcpi_rs1[31] & ((funct3 == 3'b001) || (funct3 == 3'b010))}}, pcpi_rs1};
          rs2_next    = {{32{pcpi_rs2[31] & (funct3 == 3'b001)}}, pcpi_rs2};
          rd_next     = 64'd0;
          rdx_next    = 64'd0;
          is_mul_next = (funct3 == 3'b000);
          cnt_next    = (funct3 == 3'b000) ? 7'd32 : 7'd64;
        end
      end
      RUN: begin
        if (!pcpi_valid) begin
          state_next = IDLE;
          wait_next  = 1'b0;
        end else if (cnt_reg != 7'd0) begin
          rd_next  = step_rd;
          rdx_next = step_rdt << 1;
          rs1_next = rs1_reg >> 1;
          rs2_next = rs2_reg << 1;
          cnt_next = cnt_reg - 7'd1;
        end else begin
          state_next = RESOLVE;
        end
      end
      RESOLVE: begin
        state_next = IDLE;
        if (!pcpi_valid) begin
          wait_next = 1'b0;
        end else begin
          ready_next = 1'b1;
          out_next   = is_mul_reg ? sum[31:0] : sum[63:32];
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      rs1_reg    <= 64'd0;
      rs2_reg    <= 64'd0;
      rd_reg     <= 64'd0;
      rdx_reg    <= 64'd0;
      cnt_reg    <= 7'd0;
      is_mul_reg <= 1'b0;
      out_reg    <= 32'd0;
      ready_reg  <= 1'b0;
      wait_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rs1_reg    <= rs1_next;
      rs2_reg    <= rs2_next;
      rd_reg     <= rd_next;
      rdx_reg    <= rdx_next;
      cnt_reg    <= cnt_next;
      is_mul_reg <= is_mul_next;
      out_reg    <= out_next;
      ready_reg  <= ready_next;
      wait_reg   <= wait_next;
    end
  end

  assign pcpi_wr    = ready_reg;
  assign pcpi_ready = ready_reg;
  assign pcpi_wait  = wait_reg;
  assign pcpi_rd    = out_reg;
endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: three carry-chain variants share one stimulus stream and are
// checked every cycle against a transaction-level model of the PCPI multiplier.
module tb_mul_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        wr4, wait4, ready4, wr0, wait0, ready0, wr16, wait16, ready16;
  logic [31:0] rd4, rd0, rd16;

  always #5 clk = ~clk;

  mul_seq #(.CARRY_CHAIN(4)) u_dut4 (
    .clk(clk), .reset(reset), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(wr4), .pcpi_rd(rd4),
    .pcpi_wait(wait4), .pcpi_ready(ready4));
  mul_seq #(.CARRY_CHAIN(0)) u_dut0 (
    .clk(clk), .reset(reset), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(wr0), .pcpi_rd(rd0),
    .pcpi_wait(wait0), .pcpi_ready(ready0));
  mul_seq #(.CARRY_CHAIN(16)) u_dut16 (
    .clk(clk), .reset(reset), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(wr16), .pcpi_rd(rd16),
    .pcpi_wait(wait16), .pcpi_ready(ready16));

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_insn(input logic [2:0] f3);
    return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  function automatic bit is_mul_insn(input logic [31:0] insn);
    return (insn[6:0] == 7'b0110011) && (insn[31:25] == 7'b0000001) && (insn[14:12] < 3'd4);
  endfunction

  // Reference product straight from the ISA definition: 64-bit extended operands.
  function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] a64, b64, p;
    a64 = (f3 == 3'd1 || f3 == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
    b64 = (f3 == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
    p   = a64 * b64;
    return (f3 == 3'd0) ? p[31:0] : p[63:32];
  endfunction

  // Protocol model: tracks the accepted request and the cycle its result is due.
  bit          m_busy = 1'b0;
  int          m_age = 0, m_n = 0;
  logic [31:0] m_res = 32'd0;
  logic        exp_wait = 1'b0, exp_ready = 1'b0;
  logic [31:0] exp_rd = 32'd0;

  always @(posedge clk) begin
    logic prev_ready;
    prev_ready = exp_ready;
    exp_ready  = 1'b0;
    if (reset) begin
      m_busy   = 1'b0;
      exp_wait = 1'b0;
      exp_rd   = 32'd0;
    end else if (m_busy) begin
      if (!pcpi_valid) begin
        m_busy   = 1'b0;
        exp_wait = 1'b0;
      end else begin
        m_age++;
        if (m_age == m_n + 2) begin
          exp_ready = 1'b1;
          exp_rd    = m_res;
          m_busy    = 1'b0;
        end
      end
    end else begin
      exp_wait = 1'b0;
      if (!prev_ready && pcpi_valid && is_mul_insn(pcpi_insn)) begin
        m_busy   = 1'b1;
        m_age    = 0;
        m_n      = (pcpi_insn[14:12] == 3'd0) ? 32 : 64;
        m_res    = ref_mul(pcpi_insn[14:12], pcpi_rs1, pcpi_rs2);
        exp_wait = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("c4 wait", wait4, exp_wait);   check("c4 ready", ready4, exp_ready);
      check("c4 wr", wr4, exp_ready);      check("c4 rd", rd4, exp_rd);
      check("c0 wait", wait0, exp_wait);   check("c0 ready", ready0, exp_ready);
      check("c0 wr", wr0, exp_ready);      check("c0 rd", rd0, exp_rd);
      check("c16 wait", wait16, exp_wait); check("c16 ready", ready16, exp_ready);
      check("c16 wr", wr16, exp_ready);    check("c16 rd", rd16, exp_rd);
    end
  end

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input bit pin, input logic [31:0] want, input bit scramble, input bit hold);
    int lat;
    bit got;
    int n;
    n = (f3 == 3'd0) ? 32 : 64;
    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn  = mk_insn(f3);
    pcpi_rs1   = a;
    pcpi_rs2   = b;
    if (pin) check("model pin", ref_mul(f3, a, b), want);
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (ready4) begin
        got = 1'b1;
        lat = i;
      end else if (scramble) begin
        pcpi_rs1  = $urandom;
        pcpi_rs2  = $urandom;
        pcpi_insn = mk_insn(3'($urandom_range(0, 3)));
      end
    end
    check("ready seen", 32'(got), 32'd1);
    check("latency", lat, n + 2);
    $display("op f3=%0d a=%h b=%h rd=%h lat=%0d", f3, a, b, rd4, lat);
    if (pin) begin
      check("rd c4 lit", rd4, want);
      check("rd c0 lit", rd0, want);
      check("rd c16 lit", rd16, want);
    end
    if (!hold) pcpi_valid = 1'b0;
  endtask

  // Start a MUL and withdraw it after 'steps' cycles, by reset or by dropping valid.
  task automatic do_abort(input int steps, input bit use_reset);
    int rdy;
    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn  = mk_insn(3'd0);
    pcpi_rs1   = 32'd9;
    pcpi_rs2   = 32'd11;
    repeat (steps) @(negedge clk);
    pcpi_valid = 1'b0;
    if (use_reset) reset = 1'b1;
    @(negedge clk);
    check("abort wait", wait4, 32'd0);
    if (use_reset) check("abort rd", rd4, 32'd0);
    reset = 1'b0;
    rdy = 0;
    repeat (80) begin
      @(negedge clk);
      if (ready4 || ready0 || ready16) rdy++;
    end
    check("abort no ready", rdy, 32'd0);
    $display("abort steps=%0d reset=%0d", steps, use_reset);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    logic [31:0] va, vb;
    reset      = 1'b1;
    pcpi_valid = 1'b0;
    pcpi_insn  = 32'd0;
    pcpi_rs1   = 32'd0;
    pcpi_rs2   = 32'd0;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset rd", rd4, 32'd0);
    check("reset wait", wait4, 32'd0);
    check("reset ready", ready4, 32'd0);
    reset = 1'b0;

    do_op(3'd0, 32'd7, 32'd6, 1'b1, 32'h0000002A, 1'b0, 1'b0);
    @(negedge clk);
    check("wait after ready", wait4, 32'd0);
    do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b0, 1'b0);
    do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    do_op(3'd2, 32'hFFFFFFFF, 32'h00000002, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
    do_op(3'd0, 32'h80000000, 32'h80000000, 1'b1, 32'h00000000, 1'b0, 1'b0);
    do_op(3'd3, 32'h80000001, 32'hFFFFFFFF, 1'b1, 32'h80000000, 1'b0, 1'b0);

    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn  = 32'h00B50533;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (wait4 || ready4 || wr4) cnt++;
    end
    check("add ignored", cnt, 32'd0);
    $display("add insn held 10 cycles, busy cycles=%0d", cnt);
    pcpi_valid = 1'b0;

    do_abort(10, 1'b1);
    do_abort(10, 1'b0);
    do_op(3'd0, 32'd3, 32'd5, 1'b1, 32'h0000000F, 1'b0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      va = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
      vb = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      if ($urandom_range(0, 7) == 0)
        do_abort($urandom_range(1, 60), 1'($urandom_range(0, 1)));
      else
        do_op(3'($urandom_range(0, 3)), va, vb, 1'b0, 32'd0,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    pcpi_valid = 1'b0;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
